// File: rtl/ecg_equiv_monitor.sv
// rtl/ecg_equiv_monitor.sv - equivalence monitor for a clock-gated enable register
//
// Purpose: shadows a monitored enable register with a reference register REF_Q
// and counts, over a run of N_CYC cycles, how often the monitored output D_OUT
// disagrees with the reference, how many cycles had EN low and how many cycles
// elapsed.
//
// Ports:
//   CLK        in   sole clock, rising edge
//   RST        in   asynchronous active-high reset
//   START      in   run request (honoured in IDLE and DONE)
//   D_IN       in   data input seen by the monitored register
//   EN         in   enable seen by the monitored register
//   D_OUT      in   output of the monitored register
//   BUSY       out  high in ARM and RUN
//   DONE       out  high in DONE
//   FAIL       out  ERR_CNT is nonzero
//   ERR_CNT    out  mismatches in current/last run (saturating)
//   GATED_CNT  out  RUN cycles with EN low (saturating)
//   CYC_CNT    out  RUN cycles elapsed

module ecg_equiv_monitor #(
  parameter int WIDTH = 1,
  parameter int N_CYC = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             EN,
  input  logic [WIDTH-1:0] D_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [CNT_W-1:0] ERR_CNT,
  output logic [CNT_W-1:0] GATED_CNT,
  output logic [CNT_W-1:0] CYC_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(N_CYC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] gated_q, gated_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cyc_inc;

  assign cyc_inc = cyc_q + CNT_ONE;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      ref_q   <= '0;
      err_q   <= '0;
      gated_q <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
      gated_q <= gated_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    err_d   = err_q;
    gated_d = gated_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) state_d = S_ARM;
      end
      S_ARM: begin
        // Seed the reference with what a correct register holds after this edge.
        state_d = S_RUN;
        err_d   = '0;
        gated_d = '0;
        cyc_d   = '0;
        ref_d   = EN ? D_IN : D_OUT;
      end
      S_RUN: begin
        // D_OUT now reflects the previous edge, so it is compared with the
        // reference as it stood before this edge.
        if ((D_OUT != ref_q) && (err_q != CNT_MAX)) err_d = err_q + CNT_ONE;
        if (!EN && (gated_q != CNT_MAX)) gated_d = gated_q + CNT_ONE;
        if (EN) ref_d = D_IN;
        cyc_d = cyc_inc;
        if (cyc_inc == CNT_LIMIT) state_d = S_DONE;
      end
      S_DONE: begin
        if (START) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY      = (state_q == S_ARM) || (state_q == S_RUN);
  assign DONE      = (state_q == S_DONE);
  assign FAIL      = (err_q != '0);
  assign ERR_CNT   = err_q;
  assign GATED_CNT = gated_q;
  assign CYC_CNT   = cyc_q;

endmodule

// File: tb/tb_ecg_equiv_monitor.sv
// tb/tb_ecg_equiv_monitor.sv - testbench for ecg_equiv_monitor

module tb_ecg_equiv_monitor;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       EN;
  logic [3:0] D_IN;

  // Monitored registers, one per instance, with selectable behaviour:
  // 0 correct enable register, 1 stuck at 0, 2 ignores EN, 3 stuck at all ones.
  int         mode_a, mode_b;
  logic       qa;
  logic [3:0] qb;

  logic        busy_a, done_a, fail_a;
  logic [15:0] err_a, gated_a, cyc_a;
  logic        busy_b, done_b, fail_b;
  logic [2:0]  err_b, gated_b, cyc_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-edge stimulus and the values each edge actually sampled.
  logic       stim_en  [9];
  logic [3:0] stim_din [9];
  logic       en_log   [9];
  logic [3:0] din_log  [9];
  logic [3:0] qa_log   [9];
  logic [3:0] qb_log   [9];

  typedef struct {
    int         mode;
    logic [3:0] din;   // bit k: D_IN during RUN cycle k
    logic [3:0] en;    // bit k: EN during RUN cycle k
    int         err;
    int         gated;
  } vec_t;

  vec_t tbl [7];

  ecg_equiv_monitor #(.WIDTH(1), .N_CYC(4), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .START(START), .D_IN(D_IN[0]), .EN(EN), .D_OUT(qa),
    .BUSY(busy_a), .DONE(done_a), .FAIL(fail_a),
    .ERR_CNT(err_a), .GATED_CNT(gated_a), .CYC_CNT(cyc_a)
  );

  ecg_equiv_monitor #(.WIDTH(4), .N_CYC(7), .CNT_W(3)) dut_b (
    .CLK(CLK), .RST(RST), .START(START), .D_IN(D_IN), .EN(EN), .D_OUT(qb),
    .BUSY(busy_b), .DONE(done_b), .FAIL(fail_b),
    .ERR_CNT(err_b), .GATED_CNT(gated_b), .CYC_CNT(cyc_b)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      qa <= 1'b0;
      qb <= 4'h0;
    end else begin
      case (mode_a)
        0: if (EN) qa <= D_IN[0];
        1: qa <= 1'b0;
        2: qa <= D_IN[0];
        default: qa <= 1'b1;
      endcase
      case (mode_b)
        0: if (EN) qb <= D_IN;
        1: qb <= 4'h0;
        2: qb <= D_IN;
        default: qb <= 4'hF;
      endcase
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Run-level reference: edge 0 samples START, edge 1 is the ARM edge,
  // edges 2..n+1 are the n compare cycles.
  task automatic model_run(input int n, input logic [3:0] mask, input int maxc,
                           input bit use_b, output int err, output int gated,
                           output int cyc);
    logic [3:0] r, q;
    q = use_b ? qb_log[1] : qa_log[1];
    r = en_log[1] ? (din_log[1] & mask) : (q & mask);
    err = 0; gated = 0; cyc = 0;
    for (int e = 2; e <= n + 1; e++) begin
      q = (use_b ? qb_log[e] : qa_log[e]) & mask;
      if (q != r) err = (err < maxc) ? err + 1 : err;
      if (!en_log[e]) gated = (gated < maxc) ? gated + 1 : gated;
      cyc++;
      if (en_log[e]) r = din_log[e] & mask;
    end
  endtask

  task automatic check_edge(input int k);
    check("a_busy", busy_a, (k <= 4));
    check("a_done", done_a, (k >= 5));
    check("b_busy", busy_b, (k <= 7));
    check("b_done", done_b, (k >= 8));
  endtask

  task automatic check_counts();
    int e_err, e_gated, e_cyc;
    model_run(4, 4'h1, 65535, 1'b0, e_err, e_gated, e_cyc);
    check("a_err", err_a, e_err);
    check("a_gated", gated_a, e_gated);
    check("a_cyc", cyc_a, e_cyc);
    check("a_fail", fail_a, (e_err != 0));
    model_run(7, 4'hF, 7, 1'b1, e_err, e_gated, e_cyc);
    check("b_err", err_b, e_err);
    check("b_gated", gated_b, e_gated);
    check("b_cyc", cyc_b, e_cyc);
    check("b_fail", fail_b, (e_err != 0));
  endtask

  // One START pulse followed by the prepared stimulus; starts from IDLE or DONE.
  task automatic do_run(input int ma, input int mb);
    mode_a = ma;
    mode_b = mb;
    for (int e = 0; e < 9; e++) begin
      @(negedge CLK);
      if (e > 0) check_edge(e - 1);
      START = (e == 0);
      EN    = stim_en[e];
      D_IN  = stim_din[e];
      en_log[e]  = EN;
      din_log[e] = D_IN;
      qa_log[e]  = {3'b000, qa};
      qb_log[e]  = qb;
    end
    @(negedge CLK);
    check_edge(8);
    START = 1'b0;
    EN    = 1'b0;
    check_counts();
  endtask

  task automatic apply_vec(input int t);
    for (int e = 0; e < 9; e++) begin
      if (e < 2) begin
        stim_en[e]  = 1'b1;
        stim_din[e] = {3'($urandom), 1'b0};
      end else if (e < 6) begin
        stim_en[e]  = tbl[t].en[e-2];
        stim_din[e] = {3'($urandom), tbl[t].din[e-2]};
      end else begin
        stim_en[e]  = 1'($urandom);
        stim_din[e] = 4'($urandom);
      end
    end
    do_run(tbl[t].mode, int'($urandom_range(0, 3)));
    check("tbl_err", err_a, tbl[t].err);
    check("tbl_gated", gated_a, tbl[t].gated);
    check("tbl_cyc", cyc_a, 4);
    check("tbl_fail", fail_a, (tbl[t].err != 0));
    check("tbl_done", done_a, 1);
  endtask

  initial begin
    tbl[0] = '{0, 4'b0101, 4'b1001, 0, 2};  // 11,00,10,01 on a correct register
    tbl[1] = '{1, 4'b0101, 4'b1001, 3, 2};  // same, D_OUT stuck at 0
    tbl[2] = '{2, 4'b0001, 4'b0001, 2, 3};  // 11,00,00,00 with EN ignored
    tbl[3] = '{0, 4'b0000, 4'b1111, 0, 0};
    tbl[4] = '{1, 4'b1111, 4'b1111, 3, 0};
    tbl[5] = '{2, 4'b1111, 4'b0000, 3, 4};
    tbl[6] = '{3, 4'b0000, 4'b1111, 4, 0};

    mode_a = 0; mode_b = 0;
    RST = 1'b1; START = 1'b0; EN = 1'b0; D_IN = 4'h0;
    #1;
    check("rst_a_busy", busy_a, 0);
    check("rst_a_done", done_a, 0);
    check("rst_a_fail", fail_a, 0);
    check("rst_a_err", err_a, 0);
    check("rst_a_gated", gated_a, 0);
    check("rst_a_cyc", cyc_a, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_done", done_b, 0);
    @(negedge CLK);
    RST = 1'b0;

    for (int t = 0; t < 7; t++) apply_vec(t);

    // Every cycle mismatches: instance b reaches its counter ceiling exactly.
    for (int e = 0; e < 9; e++) begin
      stim_en[e]  = (e < 2);
      stim_din[e] = (e < 2) ? 4'h0 : 4'($urandom);
    end
    do_run(3, 3);
    check("sat_a_err", err_a, 4);
    check("sat_a_gated", gated_a, 4);
    check("sat_b_err", err_b, 7);
    check("sat_b_gated", gated_b, 7);
    check("sat_b_cyc", cyc_b, 7);
    check("sat_b_fail", fail_b, 1);

    for (int r = 0; r < 12; r++) begin
      for (int e = 0; e < 9; e++) begin
        stim_en[e]  = 1'($urandom);
        stim_din[e] = 4'($urandom);
      end
      do_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset during RUN cycle 2.
    mode_a = 3; mode_b = 3;
    @(negedge CLK); START = 1'b1; EN = 1'b1; D_IN = 4'h0;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK); EN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("mid_a_err", err_a, 2);
    check("mid_b_err", err_b, 2);
    check("mid_a_busy", busy_a, 1);
    #1 RST = 1'b1;
    #1;
    check("arst_a_busy", busy_a, 0);
    check("arst_a_done", done_a, 0);
    check("arst_a_fail", fail_a, 0);
    check("arst_a_err", err_a, 0);
    check("arst_a_gated", gated_a, 0);
    check("arst_a_cyc", cyc_a, 0);
    check("arst_b_busy", busy_b, 0);
    check("arst_b_err", err_b, 0);
    check("arst_b_cyc", cyc_b, 0);
    #1 RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("idle_a_busy", busy_a, 0);
      check("idle_a_done", done_a, 0);
      check("idle_b_busy", busy_b, 0);
    end
    apply_vec(0);

    // START held high from IDLE: back-to-back runs, BUSY drops only in DONE.
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    mode_a = 0; mode_b = 0;
    for (int e = 0; e <= 18; e++) begin
      @(negedge CLK);
      if (e > 0) begin
        int k;
        bit da, db;
        k  = e - 1;
        da = (k >= 5) && ((k - 5) % 6 == 0);
        db = (k >= 8) && ((k - 8) % 9 == 0);
        check("b2b_a_busy", busy_a, !da);
        check("b2b_a_done", done_a, da);
        check("b2b_b_busy", busy_b, !db);
        check("b2b_b_done", done_b, db);
        if (da) check("b2b_a_cyc_done", cyc_a, 4);
        if (k % 6 == 1) check("b2b_a_cyc_arm", cyc_a, 0);
        if (db) check("b2b_b_cyc_done", cyc_b, 7);
        if (k % 9 == 1) check("b2b_b_cyc_arm", cyc_b, 0);
      end
      START = 1'b1;
      EN    = 1'($urandom);
      D_IN  = 4'($urandom);
    end
    START = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
